// File: rtl/data_mem_responder.sv
// Load/store data-memory responder: one request at a time, programmable wait
// states, funct3 byte lanes with sign/zero extension and error flagging.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iReq,
   input  logic        iWrEn,
   input  logic [2:0]  iFunct3,
   input  logic [31:0] iAddr,
   input  logic [31:0] iWrData,
   output logic        oReady,
   output logic        oDone,
   output logic [31:0] oRdData,
   output logic        oErr
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT =
      (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_q;
   logic [2:0]    f3_q;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic          accept;
   logic [AW-1:0] idx;
   logic          legal_st;
   logic          legal_ld;
   logic          mis;
   logic          err;
   logic [31:0]   rd_word;
   logic [31:0]   rd_sh;
   logic [31:0]   ld_val;
   logic [3:0]    be;
   logic [31:0]   wd_lane;
   logic          we;

   // Upper address bits only matter modulo the array size.
   logic unused_addr;
   assign unused_addr = ^iAddr[31:AW+2];

   assign accept = iReq & (state_q == S_IDLE);
   assign idx    = addr_q[AW+1:2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d   = CNT_INIT;
               state_d = (WAIT_CYCLES == 0) ? S_RESP : S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q    <= iWrEn;
            f3_q    <= iFunct3;
            addr_q  <= iAddr[AW+1:0];
            wdata_q <= iWrData;
         end
      end
   end

   always_comb begin
      legal_st = ~f3_q[2] & (f3_q[1:0] != 2'b11);
      legal_ld = (f3_q[1:0] != 2'b11) & ~(f3_q[2] & f3_q[1]);
      mis      = ((f3_q[1:0] == 2'b01) & addr_q[0])
               | ((f3_q[1:0] == 2'b10) & (|addr_q[1:0]));
      err      = (wr_q ? ~legal_st : ~legal_ld) | mis;
   end

   assign rd_word = mem_q[idx];
   assign rd_sh   = rd_word >> {addr_q[1:0], 3'b000};

   always_comb begin
      ld_val = '0;
      unique case (1'b1)
         (f3_q[1:0] == 2'b00):
            ld_val = {{24{~f3_q[2] & rd_sh[7]}}, rd_sh[7:0]};
         (f3_q[1:0] == 2'b01):
            ld_val = {{16{~f3_q[2] & rd_sh[15]}}, rd_sh[15:0]};
         (f3_q[1:0] == 2'b10):
            ld_val = rd_word;
         default:
            ld_val = '0;
      endcase
   end

   always_comb begin
      be      = '0;
      wd_lane = wdata_q;
      unique case (1'b1)
         (f3_q[1:0] == 2'b00): begin
            be      = 4'b0001 << addr_q[1:0];
            wd_lane = {4{wdata_q[7:0]}};
         end
         (f3_q[1:0] == 2'b01): begin
            be      = addr_q[1] ? 4'b1100 : 4'b0011;
            wd_lane = {2{wdata_q[15:0]}};
         end
         (f3_q[1:0] == 2'b10): begin
            be = 4'b1111;
         end
         default: be = '0;
      endcase
   end

   // Commit on the edge leaving RESP; reset forces IDLE so no write slips out.
   assign we = (state_q == S_RESP) & wr_q & ~err;

   always_ff @(posedge iClk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem_q[idx][8*b +: 8] <= wd_lane[8*b +: 8];
            end
         end
      end
   end

   assign oReady  = (state_q == S_IDLE);
   assign oDone   = (state_q == S_RESP);
   assign oErr    = oDone & err;
   assign oRdData = (oDone & ~wr_q & ~err) ? ld_val : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-level reference model,
// directed vectors, wrap, reset abort and randomized traffic.
module tb_data_mem_responder;

   localparam int DEPTH = 64;
   localparam int WAIT  = 3;

   logic        iClk = 1'b0;
   logic        iRst = 1'b0;
   logic        iReq = 1'b0;
   logic        iWrEn = 1'b0;
   logic [2:0]  iFunct3 = '0;
   logic [31:0] iAddr = '0;
   logic [31:0] iWrData = '0;
   logic        oReady;
   logic        oDone;
   logic [31:0] oRdData;
   logic        oErr;

   data_mem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES(WAIT)
   ) dut (
      .iClk(iClk),
      .iRst(iRst),
      .iReq(iReq),
      .iWrEn(iWrEn),
      .iFunct3(iFunct3),
      .iAddr(iAddr),
      .iWrData(iWrData),
      .oReady(oReady),
      .oDone(oDone),
      .oRdData(oRdData),
      .oErr(oErr)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          acc;
   } exp_t;

   exp_t sbq[$];
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit [31:0] mmem [DEPTH];

   always @(posedge iClk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: byte-wise memory model derived from the access rules.
   function automatic void model(input bit wr, input bit [2:0] f3,
                                 input bit [31:0] a, input bit [31:0] wd,
                                 output bit [31:0] rd, output bit err);
      int nb;
      int w;
      int off;
      bit legal;
      bit [31:0] v;
      rd = 0;
      case (f3[1:0])
         2'd0: nb = 1;
         2'd1: nb = 2;
         2'd2: nb = 4;
         default: nb = 0;
      endcase
      if (wr) legal = (f3 <= 3'd2);
      else legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      err = !legal || (nb > 0 && (a % nb) != 0);
      if (err) return;
      w = int'((a / 4) % DEPTH);
      off = int'(a % 4);
      if (wr) begin
         for (int b = 0; b < nb; b++)
            mmem[w][8*(off+b) +: 8] = wd[8*b +: 8];
      end else begin
         v = 0;
         for (int b = 0; b < nb; b++)
            v[8*b +: 8] = mmem[w][8*(off+b) +: 8];
         if (f3[2] == 1'b0 && nb < 4 && v[8*nb-1])
            for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
         rd = v;
      end
   endfunction

   task automatic req(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                      input bit [31:0] wd, input bit use_c,
                      input bit [31:0] c_rd, input bit c_err);
      exp_t e;
      bit [31:0] mrd;
      bit merr;
      bit ok;
      @(negedge iClk);
      iReq = 1'b1;
      iWrEn = wr;
      iFunct3 = f3;
      iAddr = a;
      iWrData = wd;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (oReady) begin
            ok = 1'b1;
            break;
         end
         @(negedge iClk);
      end
      if (!ok) begin
         chk("accept_timeout", 32'd0, 32'd1);
         iReq = 1'b0;
         return;
      end
      model(wr, f3, a, wd, mrd, merr);
      if (use_c) begin
         mrd = c_rd;
         merr = c_err;
      end
      @(posedge iClk);
      #1;
      e.acc = cyc;
      e.rd = mrd;
      e.err = merr;
      sbq.push_back(e);
      // Scramble fields and keep iReq high: neither may affect this access.
      iWrEn = $urandom_range(0, 1) == 1;
      iFunct3 = 3'($urandom_range(0, 7));
      iAddr = $urandom;
      iWrData = $urandom;
      for (int i = 0; i <= WAIT; i++) begin
         @(negedge iClk);
         chk("ready_low", {31'd0, oReady}, 32'd0);
      end
      @(negedge iClk);
      chk("ready_back", {31'd0, oReady}, 32'd1);
      iReq = 1'b0;
   endtask

   always @(negedge iClk) begin
      exp_t e;
      if (iRst) begin
         if (oDone) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got oDone=1 expected no response");
            end else begin
               e = sbq.pop_front();
               chk("rdata", oRdData, e.rd);
               chk("err", {31'd0, oErr}, {31'd0, e.err});
               chk("latency", cyc, e.acc + WAIT);
            end
         end else begin
            chk("idle_rdata", oRdData, 32'd0);
            chk("idle_err", {31'd0, oErr}, 32'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge iClk);
      chk("rst_ready", {31'd0, oReady}, 32'd1);
      chk("rst_done", {31'd0, oDone}, 32'd0);
      chk("rst_rdata", oRdData, 32'd0);
      chk("rst_err", {31'd0, oErr}, 32'd0);
      iRst = 1'b1;
      @(negedge iClk);
      chk("post_rst_ready", {31'd0, oReady}, 32'd1);

      for (int w = 0; w < DEPTH; w++)
         req(1'b1, 3'd2, 32'(w * 4), $urandom, 1'b0, 32'd0, 1'b0);

      req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
      req(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
      req(1'b1, 3'd0, 32'h11, 32'hAA, 1'b1, 32'h0, 1'b0);
      req(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEADAAEF, 1'b0);
      req(1'b0, 3'd0, 32'h11, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0);
      req(1'b0, 3'd4, 32'h11, 32'h0, 1'b1, 32'h000000AA, 1'b0);
      req(1'b1, 3'd1, 32'h12, 32'h1234, 1'b1, 32'h0, 1'b0);
      req(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'h1234AAEF, 1'b0);
      req(1'b0, 3'd1, 32'h12, 32'h0, 1'b1, 32'h00001234, 1'b0);
      req(1'b0, 3'd5, 32'h11, 32'h0, 1'b1, 32'h0, 1'b1);
      req(1'b1, 3'd2, 32'h13, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
      req(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'h1234AAEF, 1'b0);
      req(1'b0, 3'd3, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
      req(1'b0, 3'd2, 32'h110, 32'h0, 1'b1, 32'h1234AAEF, 1'b0);
      req(1'b1, 3'd3, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
      req(1'b1, 3'd4, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
      req(1'b0, 3'd6, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
      req(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'h1234AAEF, 1'b0);

      // Store aborted by reset during BUSY must leave memory untouched.
      @(negedge iClk);
      iReq = 1'b1;
      iWrEn = 1'b1;
      iFunct3 = 3'd2;
      iAddr = 32'h20;
      iWrData = 32'h5A5A5A5A;
      @(posedge iClk);
      #1;
      iReq = 1'b0;
      @(negedge iClk);
      iRst = 1'b0;
      #1;
      chk("abort_ready", {31'd0, oReady}, 32'd1);
      chk("abort_done", {31'd0, oDone}, 32'd0);
      repeat (2) @(negedge iClk);
      iRst = 1'b1;
      #1;
      chk("release_ready", {31'd0, oReady}, 32'd1);
      chk("release_done", {31'd0, oDone}, 32'd0);
      req(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);

      for (int n = 0; n < 200; n++)
         req($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 1023)), $urandom, 1'b0, 32'h0, 1'b0);

      repeat (10) @(negedge iClk);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
